bsg_link_oddr_phy: RTL

BSG_LINK_ODDR_PHY -- requirements
Module: bsg_link_oddr_phy

---
 rtl/bsg_link_oddr_phy.sv | 102 ++++++++++
 1 files changed

// File: rtl/bsg_link_oddr_phy.sv
// Source-synchronous DDR link transmitter: 2*width_p-bit words are sent as two halves with a forwarded clk_i/4 clock.
// Optional macro BSG_LINK_ODDR_PHY_IDLE_HOLD_EN repeats the last fired word when idle; the default sends zeros.
module bsg_link_oddr_phy #(
  parameter int width_p = 128
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [2*width_p-1:0]   data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     data_r_o,
  output logic                   clk_r_o
);

  logic [1:0]           phase_q, phase_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [width_p-1:0]   hold_q, hold_d;
  logic                 clk_q, clk_d;
  logic                 fire_s;
  logic [2*width_p-1:0] idle_word_s;
  logic [2*width_p-1:0] word_s;

  assign ready_o  = (phase_q == 2'd3) && !reset_i;
  assign fire_s   = valid_i && ready_o;
  assign data_r_o = data_q;
  assign clk_r_o  = clk_q;

`ifdef BSG_LINK_ODDR_PHY_IDLE_HOLD_EN
  logic [2*width_p-1:0] last_q, last_d;

  // Remember the most recently fired word so idle slots repeat it.
  always_comb begin
    last_d = last_q;
    if (fire_s) begin
      last_d = data_i;
    end else begin
      last_d = last_q;
    end
  end

  // Last-word register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign idle_word_s = last_q;
`else
  assign idle_word_s = '0;
`endif

  // Word launched this slot: the fired word, otherwise the idle word.
  always_comb begin
    word_s = idle_word_s;
    if (fire_s) begin
      word_s = data_i;
    end else begin
      word_s = idle_word_s;
    end
  end

  // Next-state: phase 3 launches the low half, phase 1 swaps in the high half.
  always_comb begin
    phase_d = phase_q + 2'd1;
    data_d  = data_q;
    hold_d  = hold_q;
    case (phase_q)
      2'd3: begin
        data_d = word_s[width_p-1:0];
        hold_d = word_s[2*width_p-1:width_p];
      end
      2'd1: begin
        data_d = hold_q;
      end
      default: begin
        data_d = data_q;
        hold_d = hold_q;
      end
    endcase
    // Forwarded clock is high in phases 1 and 2, centring each half on an edge.
    clk_d = (phase_q == 2'd0) || (phase_q == 2'd1);
  end

  // State registers; reset parks the phase so the first post-reset cycle accepts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= 2'd3;
      data_q  <= '0;
      hold_q  <= '0;
      clk_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      clk_q   <= clk_d;
    end
  end

endmodule
